// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator monitor.
//   trend_e        : trend FSM state encoding (also driven on the trend port)
//   FLG_EQ/A/B     : the only legal {eq,neq,big_a,big_b} patterns
//   flags_to_trend : maps a flag pattern to its trend state (IDLE if illegal)
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TR_EQ = 2'd1,
    TR_A  = 2'd2,
    TR_B  = 2'd3
  } trend_e;

  localparam logic [3:0] FLG_EQ = 4'b1000;
  localparam logic [3:0] FLG_A  = 4'b0110;
  localparam logic [3:0] FLG_B  = 4'b0101;

  // IDLE doubles as the "illegal pattern" marker since no legal sample maps to it.
  function automatic trend_e flags_to_trend(input logic [3:0] flags);
    trend_e t;
    case (flags)
      FLG_EQ:  t = TR_EQ;
      FLG_A:   t = TR_A;
      FLG_B:   t = TR_B;
      default: t = IDLE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear to zero (wins over inc)
//   inc          : increment by one unless already at all-ones
//   q            : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/cmp_monitor.sv
// Registered monitor placed after the 4-bit comparator. Counts legal outcomes,
// tracks the outcome trend, pulses on runs of STREAK equal results and keeps a
// sticky error for illegal flag combinations.
//   clk, reset_n             : clock, asynchronous active-low reset
//   in_valid                 : flags are meaningful this cycle
//   eq, neq, big_a, big_b    : comparator flags
//   clear                    : synchronous clear of counters, FSM, run counter, error
//   cnt_eq, cnt_a, cnt_b     : saturating outcome counters
//   trend                    : current trend state (cmp_pkg::trend_e)
//   trend_chg                : pulse when trend moves between two different non-IDLE states
//   streak_hit               : pulse on the STREAK-th consecutive equal sample
//   flag_err                 : sticky illegal-combination error
module cmp_monitor
  import cmp_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int STREAK = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             eq,
  input  logic             neq,
  input  logic             big_a,
  input  logic             big_b,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [1:0]       trend,
  output logic             trend_chg,
  output logic             streak_hit,
  output logic             flag_err
);

  localparam logic [3:0] STREAK_C = 4'(STREAK);

  logic [3:0] flags;
  trend_e     outcome;
  logic       legal;
  logic       take;

  trend_e     state_q, state_d;
  logic [3:0] run_q, run_d;
  logic [3:0] run_inc;
  logic       err_q, err_d;
  logic       chg_q, chg_d;
  logic       hit_q, hit_d;

  assign flags   = {eq, neq, big_a, big_b};
  assign outcome = flags_to_trend(flags);
  assign legal   = (outcome != IDLE);
  // clear drops the sample entirely, so nothing downstream may see it.
  assign take    = in_valid && !clear;
  assign run_inc = run_q + 4'd1;

  sat_counter #(.W(CNT_W)) u_cnt_eq (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (take && (outcome == TR_EQ)),
    .q       (cnt_eq)
  );

  sat_counter #(.W(CNT_W)) u_cnt_a (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (take && (outcome == TR_A)),
    .q       (cnt_a)
  );

  sat_counter #(.W(CNT_W)) u_cnt_b (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (take && (outcome == TR_B)),
    .q       (cnt_b)
  );

  // Next-state, run counter, error and pulse logic.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    err_d   = err_q;
    chg_d   = 1'b0;
    hit_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      run_d   = '0;
      err_d   = 1'b0;
    end else if (take) begin
      if (legal) begin
        state_d = outcome;
        chg_d   = (state_q != IDLE) && (outcome != state_q);
        if (outcome == TR_EQ) begin
          // Run counter wraps to zero on a hit so a steady eq stream re-arms.
          if (run_inc == STREAK_C) begin
            hit_d = 1'b1;
            run_d = '0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          run_d = '0;
        end
      end else begin
        err_d = 1'b1;
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      run_q   <= '0;
      err_q   <= 1'b0;
      chg_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      err_q   <= err_d;
      chg_q   <= chg_d;
      hit_q   <= hit_d;
    end
  end

  assign trend      = state_q;
  assign trend_chg  = chg_q;
  assign streak_hit = hit_q;
  assign flag_err   = err_q;

endmodule
